stopwatch_ctl: RTL and testbench
================================

# stopwatch_ctl

Control unit for the two-digit seconds stopwatch on the BASYS3 board. It debounces and edge-detects three push-buttons and runs a RUN/STOP/IDLE state machine. It drives the `init_regs` and `count_enabled` inputs of the seconds counter, and it supplies a lap-freezable copy of the counter's `{tens,ones}` BCD reading to the display path.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: consecutive identical synchronized samples required to accept a new button level (10 ms at 100 MHz); must be ≥ 1.

Ports:
- `clk`  in  1: system clock (100 MHz on board).
- `reset`  in  1: asynchronous, active-high; one clock, no other clock domains.
- `btn_start_stop`  in  1: raw button, asynchronous to `clk`.
- `btn_clear`  in  1: raw button, asynchronous.
- `btn_lap`  in  1: raw button, asynchronous.
- `time_reading`  in  8: counter output `{tens[3:0], ones[3:0]}`, BCD 00–99.
- `init_regs`  out  1: counter clear request, registered.
- `count_enabled`  out  1: counter run enable, registered.
- `disp_reading`  out  8: value for the display, registered.
- `lap_active`  out  1: display frozen at lap value.
- `state`  out  2: current FSM state, for LEDs and debug.

## Operation
- Button path, per button: 2-flop synchronizer, then debounce counter. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive synchronized samples that differ from the current debounced level. Any sample equal to the current debounced level resets the counter. A rising edge of the debounced level produces a 1-cycle pulse: `p_ss`, `p_clr` or `p_lap`. Releases produce no pulse.
- FSM states: IDLE=2'd0, RUN=2'd1, STOP=2'd2. Encoding 2'd3 is illegal and recovers to IDLE with an `init_regs` pulse.
- IDLE:
  - `p_ss` → RUN.
  - `p_clr` → IDLE, with an `init_regs` pulse.
  - `p_lap` is ignored.
- RUN:
  - `p_ss` → STOP.
  - `p_clr` → RUN, with an `init_regs` pulse; `lap_active` is cleared.
  - `p_lap` toggles `lap_active`.
- STOP:
  - `p_ss` → RUN.
  - `p_clr` → IDLE, with an `init_regs` pulse; `lap_active` is cleared.
  - `p_lap` clears `lap_active`.
- Simultaneous pulses: `p_clr` has priority over `p_ss`, which has priority over `p_lap`. Only the highest-priority pulse takes effect; the others are discarded.
- `count_enabled` = 1 exactly when the state is RUN. `init_regs` is a 1-cycle pulse registered with the transition.
- Display:
  - `lap_active` = 0: `disp_reading` <= `time_reading` every cycle.
  - `lap_active` 0→1: `disp_reading` captures `time_reading` on that edge, then holds.
  - Display wrap 99→00 needs no special handling; it follows the input.

## Timing
- Reset values: state = IDLE, `init_regs` = 1 (so the counter clears while reset is held), `count_enabled` = 0, `lap_active` = 0, `disp_reading` = 8'h00. All debounced levels = 0, all debounce counters = 0, synchronizers = 0.
- `init_regs` deasserts on the first `clk` edge after `reset` is released.
- Button latency: raw input stable high → pulse asserted 2 + `DEBOUNCE_CYCLES` cycles later. The FSM outputs change on the edge that samples the pulse.
- Run latency: `count_enabled` rises on the same edge as the state change to RUN. The counter advances from the following cycle.
- Reset asserted mid-operation forces every register to its reset value immediately, without waiting for a clock edge.
- Bounce shorter than `DEBOUNCE_CYCLES` produces no pulse. Holding a button produces exactly one pulse.

## Structure
- Shared package `stopwatch_pkg` holds:
  - state constants `ST_IDLE`, `ST_RUN`, `ST_STOP`;
  - the 8-bit BCD reading width;
  - the default `DEBOUNCE_CYCLES`.
- Sub-module `btn_debounce` contains the synchronizer, debounce counter and rising-edge pulse, with parameter `DEBOUNCE_CYCLES`. It is instantiated three times. Its counter width is `$clog2(DEBOUNCE_CYCLES+1)`.
- The FSM and display register live in `stopwatch_ctl`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Reset then release: `init_regs` = 1 during reset and low after the first edge; state = 0; `count_enabled` = 0; `disp_reading` = 00.
- Start/stop: press `btn_start_stop` for 10 cycles → exactly one pulse, state 0→1, `count_enabled` = 1. A second press → state 2, `count_enabled` = 0, `disp_reading` tracks `time_reading`.
- Bounce: toggle `btn_clear` every 2 cycles for 20 cycles, then release → no pulse, no `init_regs`. Then hold it 8 cycles → one `init_regs` pulse.
- Lap: in RUN with `time_reading` ramping 8'h37→8'h42, press `btn_lap` at 8'h39 → `disp_reading` holds 8'h39 and `lap_active` = 1. A second press → `disp_reading` follows 8'h42.
- Simultaneous: in STOP, pulse `btn_clear` and `btn_start_stop` on the same cycle → state IDLE, a single `init_regs` pulse, `count_enabled` = 0.
- Mid-run reset: in RUN with `lap_active` = 1, assert `reset` between clock edges → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// ---------------------------------------------------------------------------
// stopwatch_pkg : shared state encoding and sizes for the stopwatch control
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package stopwatch_pkg;

  localparam int READING_W           = 8;
  localparam int DEBOUNCE_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer, level debouncer, rising-edge pulse
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;

  // The pulse is registered together with the level change, so it is high
  // for exactly the first cycle of a new high debounced level.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    pulse_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_q[1];
        pulse_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

`default_nettype wire

// File: rtl/stopwatch_ctl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctl : button handling, RUN/STOP/IDLE FSM and lap display freeze
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_start_stop,
  input  logic                 btn_clear,
  input  logic                 btn_lap,
  input  logic [READING_W-1:0] time_reading,
  output logic                 init_regs,
  output logic                 count_enabled,
  output logic [READING_W-1:0] disp_reading,
  output logic                 lap_active,
  output logic [1:0]           state
);

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic       p_ss, p_clr, p_lap;

  assign btn_raw = {btn_lap, btn_clear, btn_start_stop};

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_raw[i]),
      .pulse_o(btn_pulse[i])
    );
  end

  assign p_ss  = btn_pulse[0];
  assign p_clr = btn_pulse[1];
  assign p_lap = btn_pulse[2];

  state_e               state_q;
  logic                 init_q, run_q, lap_q;
  logic [READING_W-1:0] disp_q;

  // The if/else-if chains encode clear > start/stop > lap priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b1;
      run_q   <= 1'b0;
      lap_q   <= 1'b0;
      disp_q  <= '0;
    end else begin
      init_q <= 1'b0;
      if (!lap_q) begin
        disp_q <= time_reading;
      end
      case (state_q)
        ST_IDLE: begin
          if (p_clr) begin
            init_q <= 1'b1;
          end else if (p_ss) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (p_clr) begin
            init_q <= 1'b1;
            lap_q  <= 1'b0;
          end else if (p_ss) begin
            state_q <= ST_STOP;
            run_q   <= 1'b0;
          end else if (p_lap) begin
            lap_q <= ~lap_q;
          end
        end
        ST_STOP: begin
          if (p_clr) begin
            state_q <= ST_IDLE;
            init_q  <= 1'b1;
            lap_q   <= 1'b0;
          end else if (p_ss) begin
            state_q <= ST_RUN;
            run_q   <= 1'b1;
          end else if (p_lap) begin
            lap_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          init_q  <= 1'b1;
          run_q   <= 1'b0;
          lap_q   <= 1'b0;
        end
      endcase
    end
  end

  assign init_regs     = init_q;
  assign count_enabled = run_q;
  assign lap_active    = lap_q;
  assign disp_reading  = disp_q;
  assign state         = state_q;

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_ctl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctl : scoreboard bench for stopwatch_ctl with DEBOUNCE_CYCLES=4
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stopwatch_ctl;
  import stopwatch_pkg::*;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_ss = 1'b0, btn_clr = 1'b0, btn_lap = 1'b0;
  logic [7:0] tr = 8'h00;
  logic       init_regs, count_enabled, lap_active;
  logic [7:0] disp_reading;
  logic [1:0] state;

  stopwatch_ctl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_ss),
    .btn_clear     (btn_clr),
    .btn_lap       (btn_lap),
    .time_reading  (tr),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .disp_reading  (disp_reading),
    .lap_active    (lap_active),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int init_cnt = 0;

  always @(posedge clk) begin
    #2;
    if (init_regs === 1'b1) init_cnt++;
  end

  typedef struct {
    string      tag;
    logic [1:0] st;
    logic       ce;
    logic       lap;
    logic [7:0] disp;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [1:0] st, input logic ce,
                         input logic lap, input logic [7:0] disp);
    exp_t e;
    e.tag = tag; e.st = st; e.ce = ce; e.lap = lap; e.disp = disp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    chk("sb_nonempty", (sb_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({e.tag, ".state"}, state, e.st);
      chk({e.tag, ".count_en"}, count_enabled, e.ce);
      chk({e.tag, ".lap"}, lap_active, e.lap);
      chk({e.tag, ".disp"}, disp_reading, e.disp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic ss, input logic clr, input logic lap, input int hold);
    btn_ss = ss; btn_clr = clr; btn_lap = lap;
    cyc(hold);
    btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
    cyc(10);
  endtask

  initial begin
    // Reset held, then released
    cyc(2);
    chk("rst.init", init_regs, 1);
    chk("rst.state", state, ST_IDLE);
    chk("rst.count_en", count_enabled, 0);
    chk("rst.disp", disp_reading, 8'h00);
    chk("rst.lap", lap_active, 0);
    reset = 1'b0;
    cyc(1);
    chk("rel.init", init_regs, 0);
    tr = 8'h12;
    cyc(2);
    init_cnt = 0;

    // First start press: state must not change before the pulse is sampled
    sb_push("start_early", ST_IDLE, 1'b0, 1'b0, 8'h12);
    sb_push("start", ST_RUN, 1'b1, 1'b0, 8'h12);
    sb_push("start_held", ST_RUN, 1'b1, 1'b0, 8'h12);
    btn_ss = 1'b1;
    cyc(2 + DEB);
    sb_check();
    cyc(1);
    sb_check();
    cyc(3);
    btn_ss = 1'b0;
    cyc(10);
    sb_check();

    // Second press stops; display keeps tracking
    sb_push("stop", ST_STOP, 1'b0, 1'b0, 8'h12);
    press(1'b1, 1'b0, 1'b0, 10);
    sb_check();
    sb_push("stop_track", ST_STOP, 1'b0, 1'b0, 8'h25);
    tr = 8'h25;
    cyc(1);
    sb_check();

    // Bounce on clear: no pulse
    init_cnt = 0;
    sb_push("bounce", ST_STOP, 1'b0, 1'b0, 8'h25);
    for (int i = 0; i < 10; i++) begin
      btn_clr = ~btn_clr;
      cyc(2);
    end
    btn_clr = 1'b0;
    cyc(10);
    sb_check();
    chk("bounce.init_cnt", init_cnt, 0);

    // Held clear from STOP: one init pulse, back to IDLE
    sb_push("clear", ST_IDLE, 1'b0, 1'b0, 8'h25);
    press(1'b0, 1'b1, 1'b0, 8);
    sb_check();
    chk("clear.init_cnt", init_cnt, 1);

    // Lap capture during a ramp
    sb_push("lap_run", ST_RUN, 1'b1, 1'b0, 8'h25);
    press(1'b1, 1'b0, 1'b0, 10);
    sb_check();
    sb_push("lap_cap", ST_RUN, 1'b1, 1'b1, 8'h39);
    sb_push("lap_hold", ST_RUN, 1'b1, 1'b1, 8'h39);
    sb_push("lap_hold2", ST_RUN, 1'b1, 1'b1, 8'h39);
    tr = 8'h37;
    btn_lap = 1'b1;
    cyc(5);
    tr = 8'h38;
    cyc(1);
    tr = 8'h39;
    cyc(1);
    sb_check();
    tr = 8'h40;
    cyc(1);
    tr = 8'h41;
    cyc(1);
    tr = 8'h42;
    cyc(1);
    sb_check();
    cyc(1);
    btn_lap = 1'b0;
    cyc(10);
    sb_check();

    sb_push("lap_release", ST_RUN, 1'b1, 1'b0, 8'h42);
    press(1'b0, 1'b0, 1'b1, 10);
    sb_check();

    // start/stop beats lap when both arrive together
    sb_push("ss_over_lap", ST_STOP, 1'b0, 1'b0, 8'h42);
    press(1'b1, 1'b0, 1'b1, 10);
    sb_check();

    // clear beats start/stop in STOP
    init_cnt = 0;
    sb_push("clr_over_ss", ST_IDLE, 1'b0, 1'b0, 8'h42);
    press(1'b1, 1'b1, 1'b0, 10);
    sb_check();
    chk("clr_over_ss.init_cnt", init_cnt, 1);

    // Mid-run reset with lap frozen
    sb_push("pre_rst_run", ST_RUN, 1'b1, 1'b0, 8'h42);
    press(1'b1, 1'b0, 1'b0, 10);
    sb_check();
    sb_push("pre_rst_lap", ST_RUN, 1'b1, 1'b1, 8'h42);
    press(1'b0, 1'b0, 1'b1, 10);
    tr = 8'h55;
    cyc(2);
    sb_check();
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst.state", state, ST_IDLE);
    chk("async_rst.count_en", count_enabled, 0);
    chk("async_rst.lap", lap_active, 0);
    chk("async_rst.init", init_regs, 1);
    chk("async_rst.disp", disp_reading, 8'h00);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    chk("async_rel.init", init_regs, 0);
    chk("async_rel.disp", disp_reading, 8'h55);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
